mem_stage_ctrl: RTL

MEM-stage controller: the downstream consumer of the EXE→MEM pipeline register. It decodes the latched 128-bit MEM bundle, runs data-memory load/store transactions over a req/ack interface, detects address-alignment exceptions, and drives the `MEM_over`/`MEM_allow_in` handshake that paces the EXE→MEM register. It presents a {IR, PC4, AO, DR} bundle to the MEM→WB register.

---
 rtl/mips_mem_pkg.sv | 50 +++++
 rtl/mem_align.sv | 116 +++++++++++
 rtl/mem_stage_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
//   Shared definitions for the MEM-stage controller:
//     - load/store opcodes (IR[31:26])
//     - FSM state encoding for the data-memory transaction
//     - internal load-type encoding used to extend returned read data
//     - bit offsets of the fields inside the 128-bit EXE->MEM bundle
//     - bit positions of the address exceptions in MEM_OUT_EXC
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    // Memory opcodes
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Transaction FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    // How returned read data is selected and extended.
    // LD_NONE is used for stores so the captured DR stays zero.
    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } ld_type_e;

    // Field LSB positions in MEM_IN / MEM_OUT (each field is 32 bits)
    localparam int IR_LSB  = 96;
    localparam int PC4_LSB = 64;
    localparam int AO_LSB  = 32;
    localparam int RT_LSB  = 0;

    // Exception bit positions in MEM_OUT_EXC
    localparam int EXC_ADES = 6;
    localparam int EXC_ADEL = 5;

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
//   Purely combinational helper for the MEM stage.
//   Decode side (driven from the live bundle):
//     op        in   opcode IR[31:26]
//     ao        in   effective address
//     rt        in   store source register value
//     is_load   out  opcode is LB/LH/LW/LBU/LHU
//     is_store  out  opcode is SB/SH/SW
//     align_err out  address misaligned for the access size
//     ld_kind   out  ld_type_e of the load (LD_NONE for non-loads)
//     st_wstrb  out  little-endian byte enables for a store
//     st_wdata  out  store data replicated across the enabled lanes
//   Extract side (driven from the latched request):
//     ex_kind   in   ld_type_e captured when the request was issued
//     ex_off    in   AO[1:0] captured when the request was issued
//     rdata     in   raw word from data memory
//     ld_data   out  selected and sign/zero-extended load value
// ---------------------------------------------------------------------------
module mem_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] ao,
    input  logic [31:0] rt,
    output logic        is_load,
    output logic        is_store,
    output logic        align_err,
    output logic [2:0]  ld_kind,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ex_kind,
    input  logic [1:0]  ex_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    // Decode, alignment check and store lane steering
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        is_load   = 1'b0;
        is_store  = 1'b0;
        align_err = 1'b0;
        ld_kind   = LD_NONE;
        st_wstrb  = 4'b0000;
        st_wdata  = 32'h0;
        case (op)
            OP_LB: begin
                is_load = 1'b1;
                ld_kind = LD_B;
            end
            OP_LBU: begin
                is_load = 1'b1;
                ld_kind = LD_BU;
            end
            OP_LH: begin
                is_load   = 1'b1;
                ld_kind   = LD_H;
                align_err = ao[0];
            end
            OP_LHU: begin
                is_load   = 1'b1;
                ld_kind   = LD_HU;
                align_err = ao[0];
            end
            OP_LW: begin
                is_load   = 1'b1;
                ld_kind   = LD_W;
                align_err = |ao[1:0];
            end
            OP_SB: begin
                is_store = 1'b1;
                st_wstrb = 4'b0001 << ao[1:0];
                st_wdata = {4{rt[7:0]}};
            end
            OP_SH: begin
                is_store  = 1'b1;
                align_err = ao[0];
                st_wstrb  = 4'b0011 << ao[1:0];
                st_wdata  = {2{rt[15:0]}};
            end
            OP_SW: begin
                is_store  = 1'b1;
                align_err = |ao[1:0];
                st_wstrb  = 4'b1111;
                st_wdata  = rt;
            end
            default: ;
        endcase
    end

    // Load extraction: pick the addressed byte/half, then extend
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (ex_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ex_off[1] ? rdata[31:16] : rdata[15:0];

        case (ld_type_e'(ex_kind))
            LD_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ld_data = {24'h0, byte_sel};
            LD_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ld_data = {16'h0, half_sel};
            LD_W:    ld_data = rdata;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM-stage controller consuming the EXE->MEM register. Decodes the bundle,
//   runs one data-memory transaction per load/store over a req/ack bus,
//   raises adel/ades on misaligned accesses and paces the upstream register
//   through MEM_over / MEM_allow_in.
//
//   Ports
//     clk            in   rising-edge clock
//     reset          in   asynchronous active-low reset
//     cancel         in   exception flush from CP0
//     WB_allow_in    in   MEM->WB register can accept
//     MEM_IN         in   {IR, PC4, AO, RT}; IR == 0 is a bubble
//     MEM_IN_EXC     in   upstream flags {ov, ri, break, syscall, if_adel}
//     MEM_IN_DELAY   in   delay-slot flag
//     MEM_over       out  result valid this cycle
//     MEM_allow_in   out  MEM_over & WB_allow_in
//     MEM_OUT        out  {IR, PC4, AO, DR}
//     MEM_OUT_EXC    out  {ades, adel, MEM_IN_EXC}
//     MEM_OUT_DELAY  out  MEM_IN_DELAY pass-through
//     mem_badvaddr   out  AO on an address exception, else 0
//     dm_req         out  request, held until dm_ack
//     dm_wr          out  1 = store
//     dm_addr        out  word-aligned address
//     dm_wstrb       out  byte enables
//     dm_wdata       out  store data
//     dm_ack         in   request accepted; dm_rdata valid this cycle
//     dm_rdata       in   read data
// ---------------------------------------------------------------------------
module mem_stage_ctrl
    import mips_mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         cancel,
    input  logic         WB_allow_in,
    input  logic [127:0] MEM_IN,
    input  logic [4:0]   MEM_IN_EXC,
    input  logic         MEM_IN_DELAY,
    output logic         MEM_over,
    output logic         MEM_allow_in,
    output logic [127:0] MEM_OUT,
    output logic [6:0]   MEM_OUT_EXC,
    output logic         MEM_OUT_DELAY,
    output logic [31:0]  mem_badvaddr,
    output logic         dm_req,
    output logic         dm_wr,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wstrb,
    output logic [31:0]  dm_wdata,
    input  logic         dm_ack,
    input  logic [31:0]  dm_rdata
);

    // Bundle fields
    logic [31:0] ir, pc4, ao, rt;
    assign ir  = MEM_IN[IR_LSB  +: 32];
    assign pc4 = MEM_IN[PC4_LSB +: 32];
    assign ao  = MEM_IN[AO_LSB  +: 32];
    assign rt  = MEM_IN[RT_LSB  +: 32];

    // Decode / steering / extraction
    logic        is_load, is_store, align_err;
    logic [2:0]  ld_kind;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    // Latched request, stable from issue until ack regardless of MEM_IN
    logic        lat_wr;
    logic [31:0] lat_addr;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_ld_kind;
    logic [1:0]  lat_off;

    logic [31:0] dr_q;
    logic        drop_q;
    state_e      state_q, state_d;

    mem_align u_align (
        .op        (ir[31:26]),
        .ao        (ao),
        .rt        (rt),
        .is_load   (is_load),
        .is_store  (is_store),
        .align_err (align_err),
        .ld_kind   (ld_kind),
        .st_wstrb  (st_wstrb),
        .st_wdata  (st_wdata),
        .ex_kind   (lat_ld_kind),
        .ex_off    (lat_off),
        .rdata     (dm_rdata),
        .ld_data   (ld_data)
    );

    logic adel, ades, mem_op, start;
    assign adel   = is_load  & align_err;
    assign ades   = is_store & align_err;
    // Anything flagged upstream or misaligned completes without touching memory
    assign mem_op = (is_load | is_store) & ~(|MEM_IN_EXC) & ~align_err;
    assign start  = (state_q == IDLE) & mem_op & ~cancel;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_op && !cancel) state_d = REQ;
            // A cancel arriving in the ack cycle drops the result as well
            REQ:  if (dm_ack) state_d = (drop_q || cancel) ? IDLE : DONE;
            DONE: if (WB_allow_in || cancel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        MEM_over = 1'b0;
        dm_req   = 1'b0;
        case (state_q)
            IDLE: MEM_over = ~mem_op & ~cancel;
            REQ:  dm_req   = 1'b1;
            DONE: MEM_over = ~cancel;
            default: ;
        endcase
    end

    // ---------------- Request latch, drop flag, DR register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_wr      <= 1'b0;
            lat_addr    <= 32'h0;
            lat_wstrb   <= 4'h0;
            lat_wdata   <= 32'h0;
            lat_ld_kind <= LD_NONE;
            lat_off     <= 2'd0;
            drop_q      <= 1'b0;
            dr_q        <= 32'h0;
        end else begin
            if (start) begin
                lat_wr      <= is_store;
                lat_addr    <= {ao[31:2], 2'b00};
                lat_wstrb   <= is_store ? st_wstrb : 4'h0;
                lat_wdata   <= is_store ? st_wdata : 32'h0;
                lat_ld_kind <= ld_kind;
                lat_off     <= ao[1:0];
            end

            // The bus transaction cannot be retracted, so a cancel in REQ is
            // remembered until the ack and then the result is discarded.
            if (state_q == REQ) begin
                if (dm_ack)      drop_q <= 1'b0;
                else if (cancel) drop_q <= 1'b1;
            end else begin
                drop_q <= 1'b0;
            end

            if (state_q == REQ && dm_ack) dr_q <= ld_data;
        end
    end

    // ---------------- Bus and bundle outputs ----------------
    assign dm_wr    = lat_wr;
    assign dm_addr  = lat_addr;
    assign dm_wstrb = lat_wstrb;
    assign dm_wdata = lat_wdata;

    assign MEM_allow_in  = MEM_over & WB_allow_in;
    assign MEM_OUT_DELAY = MEM_IN_DELAY;

    // DR is only meaningful once a load has completed
    logic [31:0] dr_out;
    assign dr_out  = (state_q == DONE && is_load) ? dr_q : 32'h0;
    assign MEM_OUT = {ir, pc4, ao, dr_out};

    always_comb begin
        MEM_OUT_EXC           = {2'b00, MEM_IN_EXC};
        MEM_OUT_EXC[EXC_ADES] = ades;
        MEM_OUT_EXC[EXC_ADEL] = adel;
    end

    assign mem_badvaddr = (adel | ades) ? ao : 32'h0;

endmodule
